// File: rtl/sgd_x_rd.sv
// sgd_x_rd: credit-gated model reader. Reads every x chunk of a sample
// group once the writer has published a credit for that group, and streams
// the chunks through an 8-entry skid FIFO to the dot-product pipeline.

`ifndef MAX_BIT_WIDTH_OF_X
`define MAX_BIT_WIDTH_OF_X 16
`endif
`ifndef DIS_X_BIT_DEPTH
`define DIS_X_BIT_DEPTH 10
`endif
`ifndef NUM_BITS_PER_BANK
`define NUM_BITS_PER_BANK 4
`endif

module sgd_x_rd #(
  parameter int DATA_WIDTH_IN      = 4,
  parameter int MAX_DIMENSION_BITS = `MAX_BIT_WIDTH_OF_X,
  parameter int RD_LATENCY         = 2,
  parameter int FIFO_DEPTH_BITS    = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                started,
  input  logic [31:0]                         mini_batch_size,
  input  logic [31:0]                         dimension,
  input  logic [31:0]                         number_of_epochs,
  input  logic [31:0]                         number_of_samples,
  input  logic [7:0]                          x_wr_credit_counter,
  output logic                                x_rd_en,
  output logic [`DIS_X_BIT_DEPTH-1:0]         x_rd_addr,
  input  logic [`NUM_BITS_PER_BANK*32-1:0]    x_rd_data,
  output logic                                x_out_valid,
  output logic [`NUM_BITS_PER_BANK*32-1:0]    x_out_data,
  output logic                                x_out_last,
  input  logic                                x_out_ready,
  output logic                                x_rd_done,
  output logic                                x_rd_error,
  output logic [31:0]                         state_counters_x_rd
);

  localparam int BIT_WIDTH_OF_BANK  = 3;
  localparam int ENGINE_NUM_WIDTH   = 2;
  localparam int NUM_OF_BANKS_WIDTH = 3;
  localparam int CHUNK_SHIFT        = BIT_WIDTH_OF_BANK + ENGINE_NUM_WIDTH;
  localparam int XW                 = `NUM_BITS_PER_BANK * 32;
  localparam int AW                 = `DIS_X_BIT_DEPTH;
  localparam int MC_W               = MAX_DIMENSION_BITS;
  localparam int FD                 = 1 << FIFO_DEPTH_BITS;
  localparam logic [MC_W-1:0] MC_ONE = {{(MC_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_EPOCH = 3'd2,
    S_WAIT  = 3'd3,
    S_READ  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state_r, state_nxt_s;

  logic [31:0]          dim_r, samples_r, epochs_r, epochs_r2, num_groups_r;
  logic [31:0]          dim_chunks_s;
  logic [MC_W-1:0]      main_counter_r, main_index_r, mc_last_s;
  logic                 started_r1, started_r2;
  logic [7:0]           credit_r, credit_used_r, avail_s;
  logic [31:0]          epoch_index_r, group_index_r;
  logic                 issue_s, grp_done_s, err_set_s, is_last_s;
  logic                 x_rd_en_r, rd_last_r, done_r, error_r;
  logic [AW-1:0]        x_rd_addr_r;
  logic [RD_LATENCY-1:0] en_pipe_r, last_pipe_r;
  logic [FIFO_DEPTH_BITS:0] occ_r, cnt_r, cnt_nxt_s;
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_r, rd_ptr_r;
  logic [XW:0]          mem_r [FD];
  logic                 valid_r, wr_s, pop_s;
  logic                 unused_s;

  assign dim_chunks_s = (dim_r >> CHUNK_SHIFT) + {31'd0, (|dim_r[CHUNK_SHIFT-1:0])};
  assign mc_last_s    = main_counter_r - MC_ONE;
  assign avail_s      = credit_r - credit_used_r;
  assign is_last_s    = (main_index_r == mc_last_s);
  assign wr_s         = en_pipe_r[RD_LATENCY-1];
  assign pop_s        = valid_r & x_out_ready;

  // Two-stage job parameter registration, start synchroniser and credit capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dim_r          <= 32'd0;
      samples_r      <= 32'd0;
      epochs_r       <= 32'd0;
      epochs_r2      <= 32'd0;
      num_groups_r   <= 32'd0;
      main_counter_r <= '0;
      started_r1     <= 1'b0;
      started_r2     <= 1'b0;
      credit_r       <= 8'd0;
    end else begin
      dim_r          <= dimension;
      samples_r      <= number_of_samples;
      epochs_r       <= number_of_epochs;
      epochs_r2      <= epochs_r;
      num_groups_r   <= samples_r >> NUM_OF_BANKS_WIDTH;
      main_counter_r <= dim_chunks_s[MC_W-1:0];
      started_r1     <= started;
      started_r2     <= started_r1;
      credit_r       <= x_wr_credit_counter;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state logic plus read issue / group completion / overrun decisions.
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    grp_done_s  = 1'b0;
    err_set_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (started_r2) state_nxt_s = S_START;
        else            state_nxt_s = S_IDLE;
      end
      S_START: state_nxt_s = S_EPOCH;
      S_EPOCH: begin
        if (epoch_index_r == epochs_r2) state_nxt_s = S_DONE;
        else                            state_nxt_s = S_WAIT;
      end
      S_WAIT: begin
        // More than half the credit space ahead means the writer was overrun.
        if (avail_s > 8'd128) begin
          err_set_s   = 1'b1;
          state_nxt_s = S_DONE;
        end else if (group_index_r == num_groups_r) begin
          state_nxt_s = S_EPOCH;
        end else if (avail_s != 8'd0) begin
          state_nxt_s = S_READ;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_READ: begin
        if (main_counter_r == '0) begin
          grp_done_s  = 1'b1;
          state_nxt_s = S_WAIT;
        end else if (!occ_r[FIFO_DEPTH_BITS]) begin
          // occ below FD: MSB clear since occ never exceeds FD.
          issue_s = 1'b1;
          if (is_last_s) begin
            grp_done_s  = 1'b1;
            state_nxt_s = S_WAIT;
          end else begin
            state_nxt_s = S_READ;
          end
        end else begin
          state_nxt_s = S_READ;
        end
      end
      S_DONE:  state_nxt_s = S_DONE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Epoch/group/chunk indices, consumed credits and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_used_r <= 8'd0;
      epoch_index_r <= 32'd0;
      group_index_r <= 32'd0;
      main_index_r  <= '0;
      done_r        <= 1'b0;
      error_r       <= 1'b0;
    end else begin
      case (state_r)
        S_START: begin
          credit_used_r <= 8'd0;
          epoch_index_r <= 32'd0;
          done_r        <= 1'b0;
          error_r       <= 1'b0;
        end
        S_EPOCH: begin
          if (epoch_index_r != epochs_r2) begin
            group_index_r <= 32'd0;
            epoch_index_r <= epoch_index_r + 32'd1;
          end
        end
        S_WAIT: begin
          if (state_nxt_s == S_READ) main_index_r <= '0;
        end
        S_READ: begin
          if (issue_s)    main_index_r <= main_index_r + MC_ONE;
          if (grp_done_s) begin
            credit_used_r <= credit_used_r + 8'd1;
            group_index_r <= group_index_r + 32'd1;
          end
        end
        default: ;
      endcase
      if (state_nxt_s == S_DONE) done_r  <= 1'b1;
      if (err_set_s)             error_r <= 1'b1;
    end
  end

  // Registered BRAM read strobe/address and the last-flag delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_rd_en_r   <= 1'b0;
      x_rd_addr_r <= '0;
      rd_last_r   <= 1'b0;
      en_pipe_r   <= '0;
      last_pipe_r <= '0;
    end else begin
      x_rd_en_r   <= issue_s;
      rd_last_r   <= issue_s & is_last_s;
      if (issue_s) x_rd_addr_r <= main_index_r[AW-1:0];
      en_pipe_r   <= {en_pipe_r[RD_LATENCY-2:0], x_rd_en_r};
      last_pipe_r <= {last_pipe_r[RD_LATENCY-2:0], rd_last_r};
    end
  end

  // Occupancy = FIFO entries plus reads still in flight, so issue never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_r <= '0;
    end else begin
      case ({issue_s, pop_s})
        2'b10:   occ_r <= occ_r + {{FIFO_DEPTH_BITS{1'b0}}, 1'b1};
        2'b01:   occ_r <= occ_r - {{FIFO_DEPTH_BITS{1'b0}}, 1'b1};
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Next FIFO entry count.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({wr_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + {{FIFO_DEPTH_BITS{1'b0}}, 1'b1};
      2'b01:   cnt_nxt_s = cnt_r - {{FIFO_DEPTH_BITS{1'b0}}, 1'b1};
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Skid FIFO storage, pointers and registered valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FD; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      valid_r  <= 1'b0;
    end else begin
      if (wr_s) begin
        mem_r[wr_ptr_r] <= {last_pipe_r[RD_LATENCY-1], x_rd_data};
        wr_ptr_r        <= wr_ptr_r + {{(FIFO_DEPTH_BITS-1){1'b0}}, 1'b1};
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + {{(FIFO_DEPTH_BITS-1){1'b0}}, 1'b1};
      cnt_r   <= cnt_nxt_s;
      valid_r <= (cnt_nxt_s != '0);
    end
  end

  assign x_rd_en             = x_rd_en_r;
  assign x_rd_addr           = x_rd_addr_r;
  assign x_out_valid         = valid_r;
  assign x_out_data          = mem_r[rd_ptr_r][XW-1:0];
  assign x_out_last          = mem_r[rd_ptr_r][XW];
  assign x_rd_done           = done_r;
  assign x_rd_error          = error_r;
  assign state_counters_x_rd = {x_rd_en_r, state_r, group_index_r[19:0], epoch_index_r[7:0]};

  assign unused_s = ^{mini_batch_size, dim_chunks_s[31:MC_W], group_index_r[31:20],
                      epoch_index_r[31:8], (DATA_WIDTH_IN != 0)};

endmodule

// File: tb/tb_sgd_x_rd.sv
// Directed, table-driven bench for sgd_x_rd with a 2-cycle BRAM model.
module tb_sgd_x_rd;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         started;
  logic [31:0]  mini_batch_size, dimension, number_of_epochs, number_of_samples;
  logic [7:0]   x_wr_credit_counter;
  logic         x_rd_en;
  logic [9:0]   x_rd_addr;
  logic [127:0] x_rd_data;
  logic         x_out_valid;
  logic [127:0] x_out_data;
  logic         x_out_last;
  logic         x_out_ready;
  logic         x_rd_done, x_rd_error;
  logic [31:0]  state_counters_x_rd;

  int n_cmp = 0, n_fail = 0;
  int mon_count = 0, mon_lasts = 0, rd_cnt = 0, exp_mc = 1;
  bit mon_valid_seen = 1'b0;
  logic [127:0] b1, b2;

  always #5 clk = ~clk;

  sgd_x_rd dut (
    .clk(clk), .rst_n(rst_n), .started(started),
    .mini_batch_size(mini_batch_size), .dimension(dimension),
    .number_of_epochs(number_of_epochs), .number_of_samples(number_of_samples),
    .x_wr_credit_counter(x_wr_credit_counter),
    .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
    .x_out_valid(x_out_valid), .x_out_data(x_out_data), .x_out_last(x_out_last),
    .x_out_ready(x_out_ready), .x_rd_done(x_rd_done), .x_rd_error(x_rd_error),
    .state_counters_x_rd(state_counters_x_rd)
  );

  function automatic logic [127:0] pat(input logic [9:0] a);
    logic [31:0] w;
    w = {22'd0, a};
    return {32'h1000_0000 + w, 32'h2000_0000 + w, 32'h3000_0000 + w, 32'h4000_0000 + w};
  endfunction

  // BRAM model: data for the address presented appears two cycles later.
  always @(posedge clk) begin
    b1 <= pat(x_rd_addr);
    b2 <= b1;
  end
  assign x_rd_data = b2;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Output monitor: checks chunk order/last against the expected group shape.
  always @(negedge clk) begin
    if (rst_n) begin
      if (x_rd_en) rd_cnt++;
      if (x_out_valid) mon_valid_seen = 1'b1;
      if (x_out_valid && x_out_ready) begin
        if (exp_mc != 0) begin
          check("out_data", x_out_data, pat(10'(mon_count % exp_mc)));
          check("out_last", x_out_last, 128'((mon_count % exp_mc) == exp_mc - 1));
        end
        mon_count++;
        if (x_out_last) mon_lasts++;
      end
    end
  end

  task automatic clear_mon();
    mon_count = 0; mon_lasts = 0; rd_cnt = 0; mon_valid_seen = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; started = 1'b0; mini_batch_size = 32'd8; dimension = 32'd0;
    number_of_epochs = 32'd0; number_of_samples = 32'd0;
    x_wr_credit_counter = 8'd0; x_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic start_job(input int unsigned dim, input int unsigned ep,
                           input int unsigned samp, input logic [7:0] cred);
    dimension = dim; number_of_epochs = ep; number_of_samples = samp;
    x_wr_credit_counter = cred;
    exp_mc = int'(dim >> 5) + (((dim & 32'd31) != 0) ? 1 : 0);
    started = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (!x_rd_done && i < budget) begin @(negedge clk); i++; end
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_rd(input int budget);
    int i = 0;
    while (!x_rd_en && i < budget) begin @(negedge clk); i++; end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, x_rd_en, 0);
    check({tag, "_addr"}, x_rd_addr, 0);
    check({tag, "_valid"}, x_out_valid, 0);
    check({tag, "_data"}, x_out_data, 0);
    check({tag, "_last"}, x_out_last, 0);
    check({tag, "_done"}, x_rd_done, 0);
    check({tag, "_error"}, x_rd_error, 0);
    check({tag, "_status"}, state_counters_x_rd, 0);
  endtask

  typedef struct {
    int unsigned dim, ep, samp;
    logic [7:0]  cred;
    int          chunks, lasts, grp, epo;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] es;
    vecs[0] = '{100, 2, 16, 8'd4, 16, 4, 2, 2};
    vecs[1] = '{64,  1, 24, 8'd3,  6, 3, 3, 1};
    vecs[2] = '{0,   1, 16, 8'd2,  0, 0, 2, 1};
    vecs[3] = '{64,  0,  8, 8'd1,  0, 0, 0, 0};
    vecs[4] = '{64,  3,  7, 8'd0,  0, 0, 0, 3};
    vecs[5] = '{33,  3,  8, 8'd3,  6, 3, 1, 3};

    // Reset state
    do_reset();
    @(negedge clk);
    check_all_zero("rst");

    // Table-driven whole jobs
    for (int k = 0; k < 6; k++) begin
      do_reset();
      start_job(vecs[k].dim, vecs[k].ep, vecs[k].samp, vecs[k].cred);
      wait_done(400);
      es = {1'b0, 3'd5, 20'(vecs[k].grp), 8'(vecs[k].epo)};
      check("tbl_done", x_rd_done, 1);
      check("tbl_error", x_rd_error, 0);
      check("tbl_chunks", mon_count, vecs[k].chunks);
      check("tbl_lasts", mon_lasts, vecs[k].lasts);
      check("tbl_status", state_counters_x_rd, es);
    end

    // Basic group: addresses 0..3 back to back, valid 3 cycles after first read
    do_reset();
    start_job(128, 1, 8, 8'd0);
    repeat (12) @(negedge clk);
    check("basic_gated_rd", rd_cnt, 0);
    check("basic_gated_state", state_counters_x_rd[30:28], 3);
    @(posedge clk); #1 x_wr_credit_counter = 8'd1;
    wait_rd(10);
    for (int i = 0; i < 4; i++) begin
      check("basic_en", x_rd_en, 1);
      check("basic_addr", x_rd_addr, i);
      if (i == 2) check("basic_valid_t2", x_out_valid, 0);
      if (i == 3) check("basic_valid_t3", x_out_valid, 1);
      @(negedge clk);
    end
    check("basic_en_after", x_rd_en, 0);
    wait_done(100);
    check("basic_count", mon_count, 4);
    check("basic_lasts", mon_lasts, 1);
    check("basic_done", x_rd_done, 1);

    // Credit gating: second group held until credit reaches 2
    do_reset();
    start_job(32, 1, 16, 8'd1);
    repeat (30) @(negedge clk);
    check("gate_count", mon_count, 1);
    check("gate_state", state_counters_x_rd[30:28], 3);
    check("gate_rd_en", x_rd_en, 0);
    @(posedge clk); #1 x_wr_credit_counter = 8'd2;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("gate_resume_state", state_counters_x_rd[30:28], 4);
    wait_done(100);
    check("gate_final_count", mon_count, 2);
    check("gate_done", x_rd_done, 1);

    // Back-pressure: exactly 8 reads while stalled, stable head, then drain
    do_reset();
    x_out_ready = 1'b0;
    start_job(640, 1, 8, 8'd1);
    repeat (40) @(negedge clk);
    check("bp_reads", rd_cnt, 8);
    check("bp_valid", x_out_valid, 1);
    check("bp_data", x_out_data, pat(10'd0));
    check("bp_last", x_out_last, 0);
    repeat (5) @(negedge clk);
    check("bp_data_stable", x_out_data, pat(10'd0));
    check("bp_reads_stable", rd_cnt, 8);
    @(posedge clk); #1 x_out_ready = 1'b1;
    wait_done(200);
    check("bp_total_reads", rd_cnt, 20);
    check("bp_total_out", mon_count, 20);
    check("bp_lasts", mon_lasts, 1);

    // Credit wrap: 260 groups with credits kept a few ahead, wrapping at 256
    do_reset();
    start_job(32, 1, 2080, 8'd4);
    for (int c = 0; c < 4000 && !x_rd_done; c++) begin
      @(posedge clk); #1;
      x_wr_credit_counter = 8'((mon_lasts + 4 > 260) ? 260 : mon_lasts + 4);
    end
    repeat (10) @(negedge clk);
    check("wrap_error", x_rd_error, 0);
    check("wrap_done", x_rd_done, 1);
    check("wrap_lasts", mon_lasts, 260);
    check("wrap_groups", state_counters_x_rd[27:8], 260);

    // Overrun: credit jumps by 200
    do_reset();
    start_job(32, 1, 8000, 8'd0);
    repeat (10) @(negedge clk);
    @(posedge clk); #1 x_wr_credit_counter = 8'd200;
    repeat (4) @(negedge clk);
    check("ovr_error", x_rd_error, 1);
    check("ovr_state", state_counters_x_rd[30:28], 5);
    check("ovr_count", mon_count, 0);

    // Reset mid-READ with two reads in flight
    do_reset();
    start_job(640, 1, 8, 8'd1);
    wait_rd(30);
    @(posedge clk); #1;
    rst_n = 1'b0; started = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
    repeat (10) @(negedge clk);
    check("midrst_no_valid", mon_valid_seen, 0);
    @(posedge clk); #1 started = 1'b1;
    wait_done(200);
    check("restart_count", mon_count, 20);
    check("restart_lasts", mon_lasts, 1);
    check("restart_done", x_rd_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
